register_writeback_arbiter: RTL and testbench

Shares the register_file's single write port between two writeback sources: the single-cycle ALU path and the memory/long-latency path. Arbitration is round-robin over valid/ready handshakes. The block drives the register file's write_register_index, write_data and write_signal from a registered output stage. It also keeps a 32-entry pending-write scoreboard that flags read hazards on the two register-file read indices so the pipeline can stall.

---
 rtl/register_writeback_arbiter_pkg.sv | 9 +
 rtl/register_writeback_arbiter_round_robin.sv | 37 +++
 rtl/register_writeback_arbiter.sv | 97 +++++++++
 tb/tb_register_writeback_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/register_writeback_arbiter_pkg.sv
// rtl/register_writeback_arbiter_pkg.sv - shared sizes and requester ids for the writeback arbiter
package register_writeback_arbiter_pkg;
   localparam int REGISTER_COUNT = 32;
   localparam int INDEX_WIDTH    = 5;
   localparam int DATA_WIDTH     = 32;

   localparam logic REQUESTER_ALU = 1'b0;
   localparam logic REQUESTER_MEM = 1'b1;
endpackage

// File: rtl/register_writeback_arbiter_round_robin.sv
// rtl/register_writeback_arbiter_round_robin.sv - 2-way round-robin grant (bit 0 ALU, bit 1 mem)
module writeback_round_robin (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] valid_i,
   output logic [1:0] grant_o
);
   import register_writeback_arbiter_pkg::*;

   logic last_grant_q;
   logic last_grant_d;

   // On a tie the requester that was not granted last wins.
   always_comb begin
      grant_o = valid_i;
      if (valid_i == 2'b11) begin
         grant_o = (last_grant_q == REQUESTER_MEM) ? 2'b01 : 2'b10;
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (grant_o[1]) begin
         last_grant_d = REQUESTER_MEM;
      end else if (grant_o[0]) begin
         last_grant_d = REQUESTER_ALU;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_q <= REQUESTER_MEM;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
endmodule

// File: rtl/register_writeback_arbiter.sv
// rtl/register_writeback_arbiter.sv - shares the register file write port between ALU and memory writeback
module register_writeback_arbiter #(
   parameter int DATA_WIDTH  = register_writeback_arbiter_pkg::DATA_WIDTH,
   parameter int INDEX_WIDTH = register_writeback_arbiter_pkg::INDEX_WIDTH
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      alu_write_valid,
   input  logic [INDEX_WIDTH-1:0]    alu_write_index,
   input  logic [DATA_WIDTH-1:0]     alu_write_data,
   output logic                      alu_write_ready,
   input  logic                      mem_write_valid,
   input  logic [INDEX_WIDTH-1:0]    mem_write_index,
   input  logic [DATA_WIDTH-1:0]     mem_write_data,
   output logic                      mem_write_ready,
   input  logic                      reserve_signal,
   input  logic [INDEX_WIDTH-1:0]    reserve_index,
   input  logic [INDEX_WIDTH-1:0]    read_register_index_1,
   input  logic [INDEX_WIDTH-1:0]    read_register_index_2,
   output logic                      read_busy_1,
   output logic                      read_busy_2,
   output logic [INDEX_WIDTH-1:0]    write_register_index,
   output logic [DATA_WIDTH-1:0]     write_data,
   output logic                      write_signal,
   output logic [2**INDEX_WIDTH-1:0] pending_mask
);
   import register_writeback_arbiter_pkg::*;

   localparam int ENTRY_COUNT = 2**INDEX_WIDTH;

   logic [1:0]             grant;
   logic                   transfer;
   logic [INDEX_WIDTH-1:0] win_index;
   logic [DATA_WIDTH-1:0]  win_data;

   logic                   write_signal_q, write_signal_d;
   logic [INDEX_WIDTH-1:0] write_index_q, write_index_d;
   logic [DATA_WIDTH-1:0]  write_data_q, write_data_d;
   logic [ENTRY_COUNT-1:0] pending_q, pending_d;

   writeback_round_robin u_round_robin (
      .clock   (clock),
      .reset   (reset),
      .valid_i ({mem_write_valid, alu_write_valid}),
      .grant_o (grant)
   );

   assign alu_write_ready = grant[0] & ~reset;
   assign mem_write_ready = grant[1] & ~reset;
   assign transfer        = (grant[0] | grant[1]) & ~reset;
   assign win_index       = grant[1] ? mem_write_index : alu_write_index;
   assign win_data        = grant[1] ? mem_write_data  : alu_write_data;

   // Reserve is applied after the transfer clear so it wins on a same-index collision.
   always_comb begin
      write_signal_d = 1'b0;
      write_index_d  = write_index_q;
      write_data_d   = write_data_q;
      pending_d      = pending_q;
      if (transfer) begin
         write_signal_d       = (win_index != '0);
         write_index_d        = win_index;
         write_data_d         = win_data;
         pending_d[win_index] = 1'b0;
      end
      if (reserve_signal) begin
         pending_d[reserve_index] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         write_signal_q <= 1'b0;
         write_index_q  <= '0;
         write_data_q   <= '0;
         pending_q      <= '0;
      end else begin
         write_signal_q <= write_signal_d;
         write_index_q  <= write_index_d;
         write_data_q   <= write_data_d;
         pending_q      <= pending_d;
      end
   end

   assign read_busy_1 = (read_register_index_1 != '0) &
                        (pending_q[read_register_index_1] |
                         (write_signal_q & (write_index_q == read_register_index_1)));
   assign read_busy_2 = (read_register_index_2 != '0) &
                        (pending_q[read_register_index_2] |
                         (write_signal_q & (write_index_q == read_register_index_2)));

   assign write_signal         = write_signal_q;
   assign write_register_index = write_index_q;
   assign write_data           = write_data_q;
   assign pending_mask         = pending_q;
endmodule

// File: tb/tb_register_writeback_arbiter.sv
// tb/tb_register_writeback_arbiter.sv - directed and randomized checks against a behavioural model
module tb_register_writeback_arbiter;
   logic        clock = 1'b0;
   logic        reset;
   logic        alu_write_valid, mem_write_valid;
   logic [4:0]  alu_write_index, mem_write_index;
   logic [31:0] alu_write_data, mem_write_data;
   logic        alu_write_ready, mem_write_ready;
   logic        reserve_signal;
   logic [4:0]  reserve_index;
   logic [4:0]  read_register_index_1, read_register_index_2;
   logic        read_busy_1, read_busy_2;
   logic [4:0]  write_register_index;
   logic [31:0] write_data;
   logic        write_signal;
   logic [31:0] pending_mask;

   register_writeback_arbiter dut (
      .clock                 (clock),
      .reset                 (reset),
      .alu_write_valid       (alu_write_valid),
      .alu_write_index       (alu_write_index),
      .alu_write_data        (alu_write_data),
      .alu_write_ready       (alu_write_ready),
      .mem_write_valid       (mem_write_valid),
      .mem_write_index       (mem_write_index),
      .mem_write_data        (mem_write_data),
      .mem_write_ready       (mem_write_ready),
      .reserve_signal        (reserve_signal),
      .reserve_index         (reserve_index),
      .read_register_index_1 (read_register_index_1),
      .read_register_index_2 (read_register_index_2),
      .read_busy_1           (read_busy_1),
      .read_busy_2           (read_busy_2),
      .write_register_index  (write_register_index),
      .write_data            (write_data),
      .write_signal          (write_signal),
      .pending_mask          (pending_mask)
   );

   always #5 clock = ~clock;

   int tests_run    = 0;
   int tests_failed = 0;

   // Behavioural model: what the register file should see and what is outstanding.
   bit        m_write;
   bit [4:0]  m_index;
   bit [31:0] m_data;
   bit        m_pending [32];
   bit        m_alu_owed;   // ALU is owed the next tie
   bit        g_alu, g_mem;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic bit model_busy(input bit [4:0] idx);
      if (idx == 0) return 1'b0;
      return m_pending[idx] || (m_write && m_index == idx);
   endfunction

   function automatic logic [31:0] model_mask();
      logic [31:0] mask = '0;
      for (int i = 1; i < 32; i++) mask[i] = m_pending[i];
      return mask;
   endfunction

   task automatic model_reset();
      m_write = 0; m_index = 0; m_data = 0; m_alu_owed = 1;
      for (int i = 0; i < 32; i++) m_pending[i] = 0;
   endtask

   task automatic step(input bit r, input bit av, input bit [4:0] ai, input bit [31:0] ad,
                       input bit mv, input bit [4:0] mi, input bit [31:0] md,
                       input bit rs, input bit [4:0] ri, input bit [4:0] r1, input bit [4:0] r2);
      bit [4:0]  w_idx;
      bit [31:0] w_dat;
      @(negedge clock);
      check("write_signal", write_signal, m_write);
      check("write_index", write_register_index, m_index);
      check("write_data", write_data, m_data);
      check("pending_mask", pending_mask, model_mask());
      reset = r;
      alu_write_valid = av; alu_write_index = ai; alu_write_data = ad;
      mem_write_valid = mv; mem_write_index = mi; mem_write_data = md;
      reserve_signal = rs; reserve_index = ri;
      read_register_index_1 = r1; read_register_index_2 = r2;
      #1;
      g_alu = !r && av && (!mv || m_alu_owed);
      g_mem = !r && mv && !g_alu;
      check("alu_ready", alu_write_ready, g_alu);
      check("mem_ready", mem_write_ready, g_mem);
      check("busy_1", read_busy_1, model_busy(r1));
      check("busy_2", read_busy_2, model_busy(r2));
      if (r) begin
         model_reset();
      end else begin
         m_write = 0;
         if (g_alu || g_mem) begin
            w_idx = g_alu ? ai : mi;
            w_dat = g_alu ? ad : md;
            m_write = (w_idx != 0);
            m_index = w_idx;
            m_data = w_dat;
            m_pending[w_idx] = 0;
            m_alu_owed = g_mem;
         end
         if (rs && ri != 0) m_pending[ri] = 1;
      end
   endtask

   task automatic idle(input bit [4:0] r1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
   endtask

   bit        av, mv;
   bit [4:0]  ai, mi;
   bit [31:0] ad, md;

   initial begin
      reset = 1;
      alu_write_valid = 0; alu_write_index = 0; alu_write_data = 0;
      mem_write_valid = 0; mem_write_index = 0; mem_write_data = 0;
      reserve_signal = 0; reserve_index = 0;
      read_register_index_1 = 0; read_register_index_2 = 0;
      model_reset();
      repeat (2) @(posedge clock);

      // Single ALU write, then both requesters held for alternation.
      step(0, 1, 3, 333, 0, 0, 0, 0, 0, 3, 0);
      check("t1_ws", 32'(m_write), 1);
      idle(3);
      idle(3);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) step(0, 1, 4, 10, 1, 5, 20, 0, 0, 4, 5);
      idle(0);
      // Index 0 consumed silently.
      step(0, 0, 0, 0, 1, 0, 333, 0, 0, 0, 0);
      check("t3_ready", 32'(g_mem), 1);
      idle(0);
      // Reserve 7, then write 7 from memory.
      step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      idle(7);
      step(0, 0, 0, 0, 1, 7, 77, 0, 0, 7, 0);
      idle(7);
      idle(7);
      // Reserve and transfer on index 9 in one cycle.
      step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      step(0, 1, 9, 99, 0, 0, 0, 1, 9, 9, 0);
      idle(9);
      idle(9);
      // Pending bits then reset with both requesters held.
      step(0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 6);
      step(0, 0, 0, 0, 0, 0, 0, 1, 6, 2, 6);
      step(1, 1, 11, 1, 1, 12, 2, 0, 0, 2, 6);
      step(0, 1, 11, 1, 1, 12, 2, 0, 0, 11, 12);
      check("t6_alu_first", 32'(g_alu), 1);
      idle(11);

      av = 0; mv = 0; ai = 0; mi = 0; ad = 0; md = 0;
      for (int n = 0; n < 2000; n++) begin
         bit r;
         if (!av && $urandom_range(0, 2) != 0) begin
            av = 1; ai = 5'($urandom_range(0, 7)); ad = $urandom;
         end
         if (!mv && $urandom_range(0, 2) != 0) begin
            mv = 1; mi = 5'($urandom_range(0, 7)); md = $urandom;
         end
         r = ($urandom_range(0, 39) == 0);
         step(r, av, ai, ad, mv, mi, md, ($urandom_range(0, 2) == 0),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         if (g_alu) av = 0;
         if (g_mem) mv = 0;
      end
      idle(0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
